quadencoder_velocity: RTL and testbench
=======================================

Name: quadencoder_velocity

Overview:
Downstream consumer of the quadrature decoder's signed position count. Derives two speed measures from the count:
- windowed velocity: count delta per fixed window, good at high speed.
- edge period: clocks between count changes, good at low speed.
- Also reports direction and stall.
Outputs are registered and feed the host register map alongside position.

Parameters:
BITS, 32, width of position input and velocity output (two's complement)
WINDOW_CLKS, 50000, clocks per velocity window (>=2)
PERIOD_BITS, 24, width of period counter/output; PERIOD_MAX = 2^PERIOD_BITS-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
position  input  BITS  signed count from decoder, may step by any amount per cycle
resync  input  1  pulse when decoder count was forcibly reloaded (index zeroing); suppresses bogus deltas
velocity  output  BITS  signed count delta over last completed window
vel_valid  output  1  one-cycle strobe when velocity updates
period  output  PERIOD_BITS  clocks between last two count changes
period_valid  output  1  one-cycle strobe when period updates
direction  output  1  1 = last change positive, 0 = negative
stalled  output  1  high while no count change for PERIOD_MAX clocks

Behaviour:
- Reset (rst=1 at clock edge): all outputs 0, window timer 0, period timer 0, pos_prev and pos_latched loaded from current position, FSM=IDLE. rst has priority over every other event.
- pos_prev register: position sampled every clock; change = (position != pos_prev); step = position - pos_prev, BITS-wide modular.
- Window path:
  - Timer counts 0..WINDOW_CLKS-1.
  - On the cycle timer==WINDOW_CLKS-1: velocity <= position - pos_latched (modular, wraps at BITS); pos_latched <= position; vel_valid <= 1; timer <= 0.
  - vel_valid is 0 on all other cycles; first strobe comes WINDOW_CLKS cycles after reset release.
- resync=1:
  - pos_latched <= position; pos_prev <= position; window timer <= 0; no vel_valid that cycle.
  - Period FSM -> IDLE, period timer <= 0.
  - velocity and period keep their last values.
  - resync takes priority over window terminal and over change in the same cycle.
- Period FSM (3 states):
  - IDLE: no reference edge yet. On change: direction <= step sign bit inverted (step>0 -> 1); timer <= 1; stalled <= 0; -> MEASURING. No period_valid.
  - MEASURING: timer increments each clock.
    - On change: period <= timer; period_valid <= 1; direction updated; timer <= 1; stay.
    - If timer reaches PERIOD_MAX with no change: stalled <= 1; period <= PERIOD_MAX; no strobe; -> STALLED.
  - STALLED: timer frozen. On change: stalled <= 0; direction updated; timer <= 1; -> MEASURING. No period_valid, since the interval is unknown.
- Timing rules:
  - Consecutive-cycle changes give period=1.
  - period_valid and vel_valid may assert in the same cycle; both paths are independent.
  - Step of 0 is never a change.
  - A multi-count step is one change event; period is not divided.
- Latency: all outputs update on the clock edge at which the triggering condition is sampled (one register stage after position).
- Outputs are held between strobes; no output is combinational from inputs.

Test Plan:
- Reset/first window: WINDOW_CLKS=10, position constant 100 -> vel_valid first at cycle 10 after rst release, velocity=0; all outputs 0 during rst.
- Constant rate: position +1 every 4 clocks, WINDOW_CLKS=20 -> velocity=5 per window. First change gives no period_valid; subsequent changes give period=4, direction=1, period_valid each change.
- Reverse and wrap: BITS=8, position decrementing through 0 -> 255 -> 254. Expect direction=0. Window delta from 2 to 254 gives velocity=-4 (0xFC), not 252.
- Stall: PERIOD_BITS=4, one change then hold -> after 15 clocks stalled=1, period=15, no strobe. Next change -> stalled=0, no period_valid. Change 3 clocks later -> period=3.
- Resync: position jumps 5000 -> 0 with resync=1 mid-window -> no vel_valid that cycle, next window velocity reflects only post-resync motion, FSM back to IDLE (next change no strobe).
- Simultaneous: change on the window-terminal cycle -> vel_valid and period_valid both 1 in the same cycle, velocity includes that change. rst asserted mid-window -> timers cleared, no strobe.

Source files
------------

// File: rtl/quadencoder_velocity.sv
// quadencoder_velocity
//   Derives speed measures from the decoder's signed position count.
//   - Windowed velocity: count delta over each WINDOW_CLKS-clock window.
//   - Edge period: clocks between successive count changes, with stall
//     detection once PERIOD_MAX clocks pass without a change.
//   - Direction of the last change.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   position      signed count from the decoder (two's complement, BITS)
//   resync        decoder count was reloaded; drop the bogus delta
//   velocity      count delta over the last completed window
//   vel_valid     one-cycle strobe on velocity update
//   period        clocks between the last two count changes
//   period_valid  one-cycle strobe on period update
//   direction     1 = last change was positive
//   stalled       no count change for PERIOD_MAX clocks
module quadencoder_velocity #(
    parameter int BITS        = 32,
    parameter int WINDOW_CLKS = 50000,
    parameter int PERIOD_BITS = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BITS-1:0]        position,
    input  logic                   resync,
    output logic [BITS-1:0]        velocity,
    output logic                   vel_valid,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   period_valid,
    output logic                   direction,
    output logic                   stalled
);

    localparam int                     WT_W       = $clog2(WINDOW_CLKS);
    localparam logic [WT_W-1:0]        WIN_LAST   = WT_W'(WINDOW_CLKS - 1);
    localparam logic [PERIOD_BITS-1:0] PERIOD_MAX = '1;
    localparam logic [PERIOD_BITS-1:0] PER_ONE    = PERIOD_BITS'(1);

    typedef enum logic [1:0] {IDLE, MEASURING, STALLED} state_t;

    logic [BITS-1:0]        pos_prev, pos_latched;
    logic [WT_W-1:0]        win_timer;
    logic [PERIOD_BITS-1:0] per_timer, per_timer_nxt;
    logic [PERIOD_BITS-1:0] period_nxt;
    logic                   period_valid_nxt, direction_nxt, stalled_nxt;
    state_t                 state, state_nxt;

    logic                   change;
    logic [BITS-1:0]        step;
    logic                   step_up;

    assign change  = (position != pos_prev);
    assign step    = position - pos_prev;
    // A nonzero step with a clear sign bit is a positive move.
    assign step_up = ~step[BITS-1];

    // ---------------- window path ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_prev    <= position;
            pos_latched <= position;
            win_timer   <= '0;
            velocity    <= '0;
            vel_valid   <= 1'b0;
        end else begin
            pos_prev  <= position;
            vel_valid <= 1'b0;
            if (resync) begin
                // Restart the window from the reloaded count.
                pos_latched <= position;
                win_timer   <= '0;
            end else if (win_timer == WIN_LAST) begin
                velocity    <= position - pos_latched;
                pos_latched <= position;
                vel_valid   <= 1'b1;
                win_timer   <= '0;
            end else begin
                win_timer <= win_timer + 1'b1;
            end
        end
    end

    // ---------------- period FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            per_timer    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            direction    <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            state        <= state_nxt;
            per_timer    <= per_timer_nxt;
            period       <= period_nxt;
            period_valid <= period_valid_nxt;
            direction    <= direction_nxt;
            stalled      <= stalled_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        per_timer_nxt    = per_timer;
        period_nxt       = period;
        period_valid_nxt = 1'b0;
        direction_nxt    = direction;
        stalled_nxt      = stalled;
        if (resync) begin
            // Reloaded count gives no valid reference edge.
            state_nxt     = IDLE;
            per_timer_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (change) begin
                        direction_nxt = step_up;
                        per_timer_nxt = PER_ONE;
                        stalled_nxt   = 1'b0;
                        state_nxt     = MEASURING;
                    end
                end
                MEASURING: begin
                    if (change) begin
                        period_nxt       = per_timer;
                        period_valid_nxt = 1'b1;
                        direction_nxt    = step_up;
                        per_timer_nxt    = PER_ONE;
                    end else if (per_timer == PERIOD_MAX) begin
                        stalled_nxt = 1'b1;
                        period_nxt  = PERIOD_MAX;
                        state_nxt   = STALLED;
                    end else begin
                        per_timer_nxt = per_timer + 1'b1;
                    end
                end
                STALLED: begin
                    // Interval since the last edge is unknown: no strobe.
                    if (change) begin
                        stalled_nxt   = 1'b0;
                        direction_nxt = step_up;
                        per_timer_nxt = PER_ONE;
                        state_nxt     = MEASURING;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quadencoder_velocity.sv
// Bench for quadencoder_velocity: directed table, then random stimulus
// against a timestamp-based reference model, checked every cycle.
module tb_quadencoder_velocity;

    localparam int BITS = 8;
    localparam int WIN  = 10;
    localparam int PB   = 4;
    localparam int PMAX = (1 << PB) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            resync = 1'b0;
    logic [BITS-1:0] position = '0;
    logic [BITS-1:0] velocity;
    logic            vel_valid;
    logic [PB-1:0]   period;
    logic            period_valid;
    logic            direction;
    logic            stalled;

    int errors = 0;
    int checks = 0;

    quadencoder_velocity #(.BITS(BITS), .WINDOW_CLKS(WIN), .PERIOD_BITS(PB)) dut (
        .clk(clk), .rst(rst), .position(position), .resync(resync),
        .velocity(velocity), .vel_valid(vel_valid), .period(period),
        .period_valid(period_valid), .direction(direction), .stalled(stalled)
    );

    always #5 clk = ~clk;

    // Reference model: edge timestamps instead of running timers.
    int              n = 0;
    int              win_start = 0;
    int              ref_edge = -1;
    logic [BITS-1:0] m_prev = '0, m_lat = '0, m_vel = '0;
    logic            m_vv = 0, m_pv = 0, m_dir = 0, m_st = 0;
    int              m_per = 0;

    task automatic model_edge(input logic r, input logic rs, input logic [BITS-1:0] p);
        int step;
        n++;
        m_vv = 0;
        m_pv = 0;
        if (r) begin
            m_vel = '0; m_per = 0; m_dir = 0; m_st = 0;
            m_prev = p; m_lat = p; win_start = n; ref_edge = -1;
        end else if (rs) begin
            m_prev = p; m_lat = p; win_start = n; ref_edge = -1;
        end else begin
            if (n - win_start == WIN) begin
                m_vv = 1; m_vel = p - m_lat; m_lat = p; win_start = n;
            end
            if (p != m_prev) begin
                step = int'($signed(p - m_prev));
                m_dir = (step > 0);
                if (ref_edge >= 0 && !m_st) begin
                    m_per = n - ref_edge; m_pv = 1;
                end
                ref_edge = n;
                m_st = 0;
            end else if (ref_edge >= 0 && !m_st && n - ref_edge == PMAX) begin
                m_st = 1; m_per = PMAX;
            end
            m_prev = p;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    task automatic clk_step(input logic r, input logic rs, input logic [BITS-1:0] p);
        rst = r; resync = rs; position = p;
        @(posedge clk);
        model_edge(r, rs, p);
        #1;
        chk("model.vel_valid", int'(vel_valid), int'(m_vv));
        chk("model.velocity", int'(velocity), int'(m_vel));
        chk("model.period_valid", int'(period_valid), int'(m_pv));
        chk("model.period", int'(period), m_per);
        chk("model.direction", int'(direction), int'(m_dir));
        chk("model.stalled", int'(stalled), int'(m_st));
    endtask

    typedef struct {
        logic            r;
        logic            rs;
        logic [BITS-1:0] pos;
        int              cyc;
        logic            vv;
        logic [BITS-1:0] vel;
        logic            pv;
        logic [PB-1:0]   per;
        logic            dir;
        logic            st;
    } vec_t;

    vec_t tbl[21];

    initial begin
        logic [BITS-1:0] pos;
        int hold;
        //          rst   rsy   pos     cyc  vv    vel     pv    per     dir   st
        tbl[0]  = '{1'b1, 1'b0, 8'd100, 2,  1'b0, 8'h00, 1'b0, 4'd0,  1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'd100, 9,  1'b0, 8'h00, 1'b0, 4'd0,  1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'd100, 1,  1'b1, 8'h00, 1'b0, 4'd0,  1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'd101, 1,  1'b0, 8'h00, 1'b0, 4'd0,  1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'd101, 14, 1'b0, 8'h01, 1'b0, 4'd0,  1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'd101, 1,  1'b0, 8'h01, 1'b0, 4'd15, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'd99,  1,  1'b0, 8'h01, 1'b0, 4'd15, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'd99,  2,  1'b0, 8'h01, 1'b0, 4'd15, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'd100, 1,  1'b1, 8'hFF, 1'b1, 4'd3,  1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'd50,  1,  1'b0, 8'hFF, 1'b0, 4'd3,  1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'd50,  3,  1'b0, 8'hFF, 1'b0, 4'd3,  1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'd52,  1,  1'b0, 8'hFF, 1'b0, 4'd3,  1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'd52,  5,  1'b0, 8'hFF, 1'b0, 4'd3,  1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'd53,  1,  1'b1, 8'h03, 1'b1, 4'd6,  1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 8'd2,   1,  1'b0, 8'h03, 1'b1, 4'd1,  1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'd0,   4,  1'b0, 8'h03, 1'b0, 4'd1,  1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 8'd255, 1,  1'b0, 8'h03, 1'b1, 4'd4,  1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 8'd254, 4,  1'b1, 8'hC9, 1'b0, 4'd1,  1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 8'd7,   1,  1'b0, 8'h00, 1'b0, 4'd0,  1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 8'd7,   9,  1'b0, 8'h00, 1'b0, 4'd0,  1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 8'd7,   1,  1'b1, 8'h00, 1'b0, 4'd0,  1'b0, 1'b0};

        for (int i = 0; i < 21; i++) begin
            for (int c = 0; c < tbl[i].cyc; c++) clk_step(tbl[i].r, tbl[i].rs, tbl[i].pos);
            chk($sformatf("tbl%0d.vel_valid", i), int'(vel_valid), int'(tbl[i].vv));
            chk($sformatf("tbl%0d.velocity", i), int'(velocity), int'(tbl[i].vel));
            chk($sformatf("tbl%0d.period_valid", i), int'(period_valid), int'(tbl[i].pv));
            chk($sformatf("tbl%0d.period", i), int'(period), int'(tbl[i].per));
            chk($sformatf("tbl%0d.direction", i), int'(direction), int'(tbl[i].dir));
            chk($sformatf("tbl%0d.stalled", i), int'(stalled), int'(tbl[i].st));
        end

        // Constant rate: +1 every 5 clocks from a fresh reset.
        pos = 8'd20;
        clk_step(1'b1, 1'b0, pos);
        for (int k = 0; k < 40; k++) begin
            if (k % 5 == 4) pos = pos + 1'b1;
            clk_step(1'b0, 1'b0, pos);
        end
        chk("rate.period", int'(period), 5);
        chk("rate.velocity", int'(velocity), 2);

        // Random traffic with holds long enough to stall.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (hold > 0) begin
                hold--;
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: pos = pos + BITS'($urandom_range(1, 3));
                    5, 6:          pos = pos - BITS'($urandom_range(1, 3));
                    7:             pos = BITS'($urandom);
                    8:             hold = $urandom_range(10, 25);
                    default:       hold = $urandom_range(1, 5);
                endcase
            end
            clk_step(r == 0, (r >= 1 && r <= 3), pos);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
